// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: round-robin two-port burst arbiter/sequencer driving the hyperbus controller request inputs
module hyperbus_arbiter #(
  parameter int WIDTH = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT = 64,
  localparam int MW = 2*WIDTH/8
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m0_we,
  input  logic m0_reg_space,
  input  logic [ADDR_LENGTH-1:0] m0_adr,
  input  logic [LEN_WIDTH-1:0] m0_len,
  input  logic [2*WIDTH-1:0] m0_wdat,
  input  logic [MW-1:0] m0_mask,
  output logic m0_wready,
  output logic [2*WIDTH-1:0] m0_rdat,
  output logic m0_rvalid,
  output logic m0_done,
  output logic m0_err,
  input  logic m1_req,
  input  logic m1_we,
  input  logic m1_reg_space,
  input  logic [ADDR_LENGTH-1:0] m1_adr,
  input  logic [LEN_WIDTH-1:0] m1_len,
  input  logic [2*WIDTH-1:0] m1_wdat,
  input  logic [MW-1:0] m1_mask,
  output logic m1_wready,
  output logic [2*WIDTH-1:0] m1_rdat,
  output logic m1_rvalid,
  output logic m1_done,
  output logic m1_err,
  output logic [ADDR_LENGTH-1:0] hb_adr,
  output logic [2*WIDTH-1:0] hb_dat,
  output logic [MW:0] hb_mask,
  output logic hb_reg_space,
  output logic hb_wrq,
  output logic hb_rrq,
  input  logic hb_ready,
  input  logic hb_valid,
  input  logic [2*WIDTH-1:0] hb_rdat
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, we_q, we_d, reg_q, reg_d;
  logic wrq_q, wrq_d, rrq_q, rrq_d, done_q, done_d, err_q, err_d;
  logic [ADDR_LENGTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [MW-1:0] mask_lo;
  logic win, beat;
  assign win = (m0_req & m1_req) ? ~last_q : m1_req;
  assign beat = (wrq_q & hb_ready) | (rrq_q & hb_valid);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    we_d = we_q;
    reg_d = reg_q;
    adr_d = adr_q;
    len_d = len_q;
    beat_d = beat_q;
    to_d = to_q;
    gap_d = gap_q;
    wrq_d = wrq_q;
    rrq_d = rrq_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (m0_req | m1_req) begin
        gnt_d = win;
        last_d = win;
        we_d = win ? m1_we : m0_we;
        reg_d = win ? m1_reg_space : m0_reg_space;
        adr_d = win ? m1_adr : m0_adr;
        len_d = win ? m1_len : m0_len;
        beat_d = '0;
        to_d = '0;
        wrq_d = we_d;
        rrq_d = ~we_d;
        state_d = XFER;
      end
      XFER: if (beat) begin
        to_d = '0;
        beat_d = beat_q + 1'b1;
        if (beat_q == len_q) begin
          wrq_d = 1'b0;
          rrq_d = 1'b0;
          done_d = 1'b1;
          gap_d = '0;
          state_d = GAP;
        end
      end else if (to_q == TW'(TIMEOUT - 1)) begin
        wrq_d = 1'b0;
        rrq_d = 1'b0;
        done_d = 1'b1;
        err_d = 1'b1;
        gap_d = '0;
        state_d = GAP;
      end else begin
        to_d = to_q + 1'b1;
      end
      GAP: if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE; else gap_d = gap_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      we_q <= 1'b0;
      reg_q <= 1'b0;
      adr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      to_q <= '0;
      gap_q <= '0;
      wrq_q <= 1'b0;
      rrq_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      we_q <= we_d;
      reg_q <= reg_d;
      adr_q <= adr_d;
      len_q <= len_d;
      beat_q <= beat_d;
      to_q <= to_d;
      gap_q <= gap_d;
      wrq_q <= wrq_d;
      rrq_q <= rrq_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // outside a write beat window the controller sees a fully masked beat; idle stays at reset value
  assign mask_lo = wrq_q ? (gnt_q ? m1_mask : m0_mask) : (state_q == IDLE ? '0 : '1);
  assign hb_mask = {1'b0, mask_lo};
  assign hb_dat = wrq_q ? (gnt_q ? m1_wdat : m0_wdat) : '0;
  assign hb_adr = adr_q;
  assign hb_reg_space = reg_q;
  assign hb_wrq = wrq_q;
  assign hb_rrq = rrq_q;
  assign m0_wready = hb_ready & wrq_q & ~gnt_q;
  assign m1_wready = hb_ready & wrq_q & gnt_q;
  assign m0_rvalid = hb_valid & rrq_q & ~gnt_q;
  assign m1_rvalid = hb_valid & rrq_q & gnt_q;
  assign m0_rdat = (rrq_q & ~gnt_q) ? hb_rdat : '0;
  assign m1_rdat = (rrq_q & gnt_q) ? hb_rdat : '0;
  assign m0_done = done_q & ~gnt_q;
  assign m1_done = done_q & gnt_q;
  assign m0_err = err_q & ~gnt_q;
  assign m1_err = err_q & gnt_q;
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: table vectors, directed corner sequences and a random run against a burst-level model
module tb_hyperbus_arbiter;
  localparam int GAP = 4, TO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, we = '0, rs = '0;
  logic [31:0] adr [2];
  logic [7:0] len [2];
  logic [15:0] wdat [2];
  logic [1:0] mask [2];
  logic [1:0] wready, rvalid, done, err;
  logic [15:0] rdat [2];
  logic [31:0] hb_adr;
  logic [15:0] hb_dat;
  logic [2:0] hb_mask;
  logic hb_reg_space, hb_wrq, hb_rrq;
  logic hb_ready = 1'b0, hb_valid = 1'b0;
  logic [15:0] hb_rdat = '0;
  int nchk = 0, nerr = 0;
  int cnt, got, nw, nd, ne, ng, g, prevg, idle, k;
  int ord [4];
  int pat [5];
  logic e;
  int cur, left, silent, gapl, last, dport, nd_port;
  logic cwe, crs, derr, nerr_flag, bt;
  logic [31:0] cadr;

  typedef struct {
    logic req; logic rdy;
    logic wrq; logic wrdy; logic dn; logic er; logic [2:0] msk;
  } vec_t;
  vec_t tbl [10];

  hyperbus_arbiter #(.WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(8), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_reg_space(rs[0]), .m0_adr(adr[0]), .m0_len(len[0]),
    .m0_wdat(wdat[0]), .m0_mask(mask[0]), .m0_wready(wready[0]), .m0_rdat(rdat[0]),
    .m0_rvalid(rvalid[0]), .m0_done(done[0]), .m0_err(err[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_reg_space(rs[1]), .m1_adr(adr[1]), .m1_len(len[1]),
    .m1_wdat(wdat[1]), .m1_mask(mask[1]), .m1_wready(wready[1]), .m1_rdat(rdat[1]),
    .m1_rvalid(rvalid[1]), .m1_done(done[1]), .m1_err(err[1]),
    .hb_adr(hb_adr), .hb_dat(hb_dat), .hb_mask(hb_mask), .hb_reg_space(hb_reg_space),
    .hb_wrq(hb_wrq), .hb_rrq(hb_rrq), .hb_ready(hb_ready), .hb_valid(hb_valid), .hb_rdat(hb_rdat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    nchk++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    hb_ready = 1'b0;
    hb_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int p, output int c, output logic er);
    c = -1;
    er = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (done[p]) begin
        c = i;
        er = err[p];
        req[p] = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_wrq"}, hb_wrq, 0);
    chk({n, "_rrq"}, hb_rrq, 0);
    chk({n, "_adr"}, hb_adr, 0);
    chk({n, "_dat"}, hb_dat, 0);
    chk({n, "_mask"}, hb_mask, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_wready"}, wready, 0);
    chk({n, "_rvalid"}, rvalid, 0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      adr[p] = '0; len[p] = '0; wdat[p] = '0; mask[p] = '0;
    end
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    pat = '{0, 0, 1, 0, 1};
    tick();
    tick();
    #1;
    chk_zero("reset");
    rst = 1'b0;
    tick();
    // port 0 write, len 3, ready held high
    we[0] = 1'b1; adr[0] = 32'h100; len[0] = 8'd3; mask[0] = 2'b10; wdat[0] = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      req[0] = tbl[i].req;
      hb_ready = tbl[i].rdy;
      #1;
      chk("tbl_wrq", hb_wrq, tbl[i].wrq);
      chk("tbl_wready", wready[0], tbl[i].wrdy);
      chk("tbl_done", done[0], tbl[i].dn);
      chk("tbl_err", err[0], tbl[i].er);
      chk("tbl_mask", hb_mask, tbl[i].msk);
      chk("tbl_wready1", wready[1], 0);
      if (tbl[i].wrq) begin
        chk("tbl_adr", hb_adr, 32'h100);
        chk("tbl_dat", hb_dat, 16'h1234);
      end
      tick();
    end
    // port 1 read, len 1, irregular valid
    req[1] = 1'b1; we[1] = 1'b0; len[1] = 8'd1; adr[1] = 32'h2000; rs[1] = 1'b1;
    tick();
    k = 0;
    for (int i = 0; i < 5; i++) begin
      hb_valid = pat[i] != 0;
      hb_rdat = (pat[i] == 0) ? 16'hDEAD : (k == 0 ? 16'hA5A5 : 16'h5A5A);
      #1;
      chk("rd_rrq", hb_rrq, 1);
      chk("rd_adr", hb_adr, 32'h2000);
      chk("rd_regspace", hb_reg_space, 1);
      chk("rd_rvalid1", rvalid[1], pat[i]);
      chk("rd_rvalid0", rvalid[0], 0);
      chk("rd_rdat0", rdat[0], 0);
      if (pat[i] != 0) begin
        chk("rd_rdat1", rdat[1], (k == 0) ? 16'hA5A5 : 16'h5A5A);
        k++;
      end
      tick();
    end
    req[1] = 1'b0; hb_valid = 1'b1; hb_rdat = 16'hFFFF;
    #1;
    chk("rd_end_rrq", hb_rrq, 0);
    chk("rd_trailing_rvalid", rvalid, 0);
    chk("rd_done1", done[1], 1);
    chk("rd_err1", err[1], 0);
    chk("rd_done0", done[0], 0);
    hb_valid = 1'b0;
    repeat (6) tick();
    // simultaneous requests from reset, len 0
    do_reset();
    req = 2'b11; we[0] = 1'b1; we[1] = 1'b0; len[0] = '0; len[1] = '0;
    hb_ready = 1'b1; hb_valid = 1'b1;
    prevg = -1; idle = 0; ng = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      g = hb_wrq ? 0 : (hb_rrq ? 1 : -1);
      if (g >= 0 && prevg < 0) begin
        if (ng > 0) chk("tie_gap", idle >= GAP, 1);
        if (ng < 4) ord[ng] = g;
        ng++;
        idle = 0;
      end else if (g < 0) idle++;
      prevg = g;
      tick();
    end
    chk("tie_count", ng >= 4, 1);
    for (int i = 0; i < 4; i++) chk("tie_order", ord[i], i % 2);
    // read that never gets a valid beat
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0; len[1] = 8'd2;
    tick();
    cnt = 0;
    #1;
    while (hb_rrq && cnt < 100) begin
      cnt++;
      tick();
      #1;
    end
    chk("to_cycles", cnt, TO);
    chk("to_done", done[1], 1);
    chk("to_err", err[1], 1);
    req[1] = 1'b0;
    req[0] = 1'b1; we[0] = 1'b1; len[0] = '0; hb_ready = 1'b1;
    tick();
    wait_done(0, got, e);
    chk("to_next_done", got >= 0, 1);
    chk("to_next_err", e, 0);
    tick();
    // reset in the middle of an 8-beat write
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; len[0] = 8'd7; hb_ready = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; len[0] = '0;
    #1;
    chk_zero("midrst");
    tick();
    #1;
    chk("midrst_wrq", hb_wrq, 1);
    chk("midrst_rrq", hb_rrq, 0);
    chk("midrst_wready", wready, 2'b01);
    req[0] = 1'b0;
    tick();
    #1;
    chk("midrst_done", done, 2'b01);
    // requester drops req after first beat
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; len[0] = 8'd3; hb_ready = 1'b1;
    tick();
    #1;
    chk("drop_first", wready[0], 1);
    nw = 1; nd = 0; ne = 0;
    req[0] = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      nw += int'(wready[0]);
      nd += int'(done[0]);
      ne += int'(err[0]);
      tick();
    end
    chk("drop_beats", nw, 4);
    chk("drop_done", nd, 1);
    chk("drop_err", ne, 0);
    // random traffic against a burst-level model
    do_reset();
    cur = -1; left = 0; silent = 0; gapl = 0; last = 1; dport = -1; derr = 1'b0;
    cwe = 1'b0; crs = 1'b0; cadr = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 3) == 0) begin
          req[p] = 1'b1;
          we[p] = 1'($urandom);
          rs[p] = 1'($urandom);
          adr[p] = $urandom;
          len[p] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 4));
        end
        wdat[p] = 16'($urandom);
        mask[p] = 2'($urandom);
      end
      hb_ready = $urandom_range(0, 3) != 0;
      hb_valid = $urandom_range(0, 3) != 0;
      hb_rdat = 16'($urandom);
      #1;
      bt = (cur >= 0) && (cwe ? hb_ready : hb_valid);
      chk("rnd_wrq", hb_wrq, cur >= 0 && cwe);
      chk("rnd_rrq", hb_rrq, cur >= 0 && !cwe);
      for (int p = 0; p < 2; p++) begin
        chk("rnd_wready", wready[p], cur == p && cwe && hb_ready);
        chk("rnd_rvalid", rvalid[p], cur == p && !cwe && hb_valid);
        chk("rnd_done", done[p], dport == p);
        chk("rnd_err", err[p], dport == p && derr);
        if (cur == p && !cwe && hb_valid) chk("rnd_rdat", rdat[p], hb_rdat);
        if (cur == 1 - p && !cwe) chk("rnd_rdat_other", rdat[p], 0);
      end
      if (cur >= 0) begin
        chk("rnd_adr", hb_adr, cadr);
        chk("rnd_regspace", hb_reg_space, crs);
        if (cwe) begin
          chk("rnd_dat", hb_dat, wdat[cur]);
          chk("rnd_mask", hb_mask, {1'b0, mask[cur]});
        end
      end else if (gapl > 0) chk("rnd_gap_mask", hb_mask, 3'b011);
      nd_port = -1;
      nerr_flag = 1'b0;
      if (cur >= 0) begin
        if (bt) begin
          silent = 0;
          left--;
          if (left == 0) begin nd_port = cur; cur = -1; gapl = GAP; end
        end else begin
          silent++;
          if (silent == TO) begin nd_port = cur; nerr_flag = 1'b1; cur = -1; gapl = GAP; end
        end
      end else if (gapl > 0) gapl--;
      else if (req != 2'b00) begin
        cur = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
        last = cur;
        cwe = we[cur];
        crs = rs[cur];
        cadr = adr[cur];
        left = int'(len[cur]) + 1;
        silent = 0;
      end
      if (dport >= 0) req[dport] = 1'b0;
      dport = nd_port;
      derr = nerr_flag;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Two-port arbiter and burst sequencer in front of the `hyperbus` leader controller. It accepts fixed-length burst requests from two independent requesters, for example CPU and DMA. It grants one requester at a time with round-robin fairness and drives the controller's `adr_i`/`dat_i`/`mask_i`/`wrq`/`rrq`/`reg_space_i` inputs. It counts `ready`/`valid` beats to terminate each burst and enforces an inter-burst gap and a beat timeout.

## Interface
- `WIDTH`, 8: HyperBus DQ width; beat width is `2*WIDTH`.
- `ADDR_LENGTH`, 32: address width.
- `LEN_WIDTH`, 8: burst length field width; a burst is `len+1` beats.
- `GAP_CYCLES`, 4: idle cycles between bursts (min 1).
- `TIMEOUT`, 64: max cycles waiting for any single beat.
- MW = `2*WIDTH/8` is the requester mask width.

- `clk`  in  1  memory clock, same domain as `hyperbus.clk`.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `mN_req`  in  1  request, N∈{0,1}. Hold high until `mN_done`.
- `mN_we`  in  1  1=write, 0=read.
- `mN_reg_space`  in  1  register-space access.
- `mN_adr`  in  ADDR_LENGTH  start address.
- `mN_len`  in  LEN_WIDTH  beats minus one.
- `mN_wdat`  in  2*WIDTH  write beat.
- `mN_mask`  in  MW  write byte mask, 1=masked.
- `mN_wready`  out  1  `mN_wdat` consumed this cycle.
- `mN_rdat`  out  2*WIDTH  read beat.
- `mN_rvalid`  out  1  `mN_rdat` valid this cycle.
- `mN_done`  out  1  one-cycle pulse, burst finished.
- `mN_err`  out  1  qualifies `mN_done`: burst aborted by timeout.
- `hb_adr`  out  ADDR_LENGTH  to controller `adr_i`.
- `hb_dat`  out  2*WIDTH  to `dat_i`.
- `hb_mask`  out  MW+1  to `mask_i`; MSB always 0.
- `hb_reg_space`  out  1  to `reg_space_i`.
- `hb_wrq`, `hb_rrq`  out  1  to `wrq`, `rrq`.
- `hb_ready`  in  1  from controller `ready`.
- `hb_valid`  in  1  from controller `valid`.
- `hb_rdat`  in  2*WIDTH  from controller `dat_o`.

## Operation
**States: IDLE, XFER, GAP.**

**IDLE**
- If any `mN_req` is high, pick a winner:
  - Only one request pending: it wins.
  - Both pending: the port other than `last_grant` wins.
- At the same edge:
  - Latch `gnt`, `we`, `reg_space`, `adr`, `len`.
  - Clear `beat_cnt` and `to_cnt`.
  - Set `hb_wrq` or `hb_rrq`.
  - Update `last_grant`.
  - Go to XFER.

**XFER, write**
- `hb_dat` and `hb_mask[MW-1:0]` are combinationally muxed from the granted port.
- `mGnt_wready = hb_ready & hb_wrq`.
- Each cycle with `hb_ready & hb_wrq`: `beat_cnt` increments and `to_cnt` clears.
- At the beat where `beat_cnt==len`, at that edge:
  - Clear `hb_wrq`.
  - Pulse `done` next cycle.
  - Go to GAP.
- While `hb_wrq` is low, `hb_mask[MW-1:0]` is all-ones. Any trailing controller beats are therefore fully masked and `wready` stays low.

**XFER, read**
- `mGnt_rvalid = hb_valid & hb_rrq`.
- `mGnt_rdat = hb_rdat`; the non-granted port's `rdat` is 0.
- Beat counting and termination follow the write case using `hb_valid`.
- `hb_valid` while `hb_rrq` is low is discarded.

**Timeout**
- `to_cnt` increments on every XFER cycle without a beat.
- When `to_cnt` reaches `TIMEOUT-1`:
  - Clear the request.
  - Pulse `done` with `err=1`.
  - Go to GAP.

**GAP**
- Hold all `hb_*rq` low for `GAP_CYCLES` cycles, then return to IDLE.
- GAP covers controller recovery; the controller itself adds idle cycles.

**Boundary rules**
- `mN_req` dropping mid-burst is ignored; the burst runs to `len+1` beats.
- A new request seen during XFER or GAP waits; it is not lost while held.
- `len=0`: a single beat.
- `len` all-ones: 2^LEN_WIDTH beats, and `beat_cnt` does not wrap before the compare.
- `hb_adr` holds the latched start address for the whole burst.

**Reset**
- All outputs reset to 0: `hb_wrq`, `hb_rrq`, `done`, `err`, `wready`, `rvalid`, `hb_adr`, `hb_dat`, `hb_mask`.
- State resets to IDLE and `last_grant` to 1, so port 0 wins the first tie.
- Reset mid-burst aborts immediately with no `done` pulse.

## Timing
- Grant latency: `req` seen high at edge E gives `hb_*rq` high in the cycle after E.
- Idle-to-idle minimum: 1 (grant) + beats + `GAP_CYCLES`, plus the controller's command and latency cycles.
- `wready` and `rvalid` are combinational from `hb_ready` and `hb_valid`, with zero added latency.
- `done`/`err` are registered and asserted the cycle after the final beat or the timeout.
- Arbitration is evaluated only in IDLE, one decision per burst.

## Test plan
- Port 0 write, `adr=0x100`, `len=3`, `hb_ready` held high → 4 `m0_wready` pulses; `hb_wrq` low after the 4th edge; the following cycle has `hb_mask=0b011` (MSB 0, data bits masked); `m0_done` pulses once with `err=0`.
- Port 1 read, `len=1`, `hb_valid` pulsed at irregular gaps with `0xA5A5` then `0x5A5A` → `m1_rvalid` ×2 with those values; a third `hb_valid` after termination is ignored; port 0 `rvalid` stays 0.
- Both `req` high from reset, each `len=0` → grant order 0,1,0,1; each grant separated by ≥ `GAP_CYCLES` idle cycles.
- Read with `hb_valid` never asserting, `TIMEOUT=64` → `hb_rrq` drops after 64 XFER cycles; `done` and `err` pulse together; the next request is served normally.
- Assert `rst` for 1 cycle during beat 2 of an 8-beat write → next cycle all outputs are 0 and state is IDLE with no `done`; a subsequent port-0 request is granted first.
- `m0_req` deasserted after the 1st beat of a `len=3` write → all 4 beats are still counted and `done` pulses.
